// File: rtl/div_ratio_pkg.sv
// Shared types, ratio codes and period legality helper for the divided-clock
// ratio detector.
package div_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        LOCK  = 2'd3
    } state_e;

    localparam logic [1:0] DIV2  = 2'b00;
    localparam logic [1:0] DIV4  = 2'b01;
    localparam logic [1:0] DIV8  = 2'b10;
    localparam logic [1:0] DIV16 = 2'b11;

    localparam int unsigned PER_DIV2  = 2;
    localparam int unsigned PER_DIV4  = 4;
    localparam int unsigned PER_DIV8  = 8;
    localparam int unsigned PER_DIV16 = 16;

    typedef struct packed {
        logic       legal;
        logic [1:0] code;
    } period_chk_t;

    // A period is legal only at one of the four ratios with exactly 50% high time.
    function automatic period_chk_t period_to_code(input int unsigned per,
                                                   input int unsigned hi);
        period_chk_t r;
        r.legal = 1'b0;
        r.code  = DIV2;
        case (per)
            PER_DIV2: begin
                r.legal = (hi == PER_DIV2 / 2);
                r.code  = DIV2;
            end
            PER_DIV4: begin
                r.legal = (hi == PER_DIV4 / 2);
                r.code  = DIV4;
            end
            PER_DIV8: begin
                r.legal = (hi == PER_DIV8 / 2);
                r.code  = DIV8;
            end
            PER_DIV16: begin
                r.legal = (hi == PER_DIV16 / 2);
                r.code  = DIV16;
            end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/div_ratio_detect_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level with a rising-edge detect.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync   = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/div_ratio_detect.sv
// Recovers the /2,/4,/8,/16 ratio code from a divided clock sampled in the
// system domain, with duty check, two-period lock and stall detection.
module div_ratio_detect
    import div_ratio_pkg::*;
#(
    parameter int unsigned PER_W       = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_in,
    output logic [1:0] ratio,
    output logic       valid,
    output logic       err,
    output logic       stall
);

    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);

    logic             w_s;
    logic             w_rise;
    logic             w_timeout;
    period_chk_t      w_chk;

    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W-1:0] r_hi_cnt;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_cand;
    logic [1:0]       w_cand_nxt;
    logic [1:0]       r_ratio;
    logic [1:0]       w_ratio_nxt;
    logic             w_err_nxt;
    logic             r_err;
    logic             r_valid;
    logic             r_stall;
    logic             w_stall_nxt;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (clk_in),
        .o_sync  (w_s),
        .o_rise_c(w_rise)
    );

    // Period and high-time counters restart at 1 on every rise, so at the
    // next rise they hold the full period and high time of the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_rise) begin
            r_per_cnt <= CNT_ONE;
            r_hi_cnt  <= CNT_ONE;
        end else begin
            if (r_per_cnt != PER_MAX) begin
                r_per_cnt <= r_per_cnt + CNT_ONE;
            end
            if (w_s && (r_hi_cnt != PER_MAX)) begin
                r_hi_cnt <= r_hi_cnt + CNT_ONE;
            end
        end
    end

    assign w_chk     = period_to_code(32'(r_per_cnt), 32'(r_hi_cnt));
    assign w_timeout = (r_state != IDLE) && (r_per_cnt == PER_MAX) && !w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= DIV2;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Rise handling has priority over timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_ratio_nxt = r_ratio;
        w_err_nxt   = 1'b0;
        w_stall_nxt = r_stall;

        if (w_rise) begin
            w_stall_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARMED;
                end
                ARMED: begin
                    if (w_chk.legal) begin
                        w_cand_nxt  = w_chk.code;
                        w_state_nxt = CHECK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                CHECK: begin
                    if (!w_chk.legal) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ARMED;
                    end else if (w_chk.code == r_cand) begin
                        w_ratio_nxt = r_cand;
                        w_state_nxt = LOCK;
                    end else begin
                        w_cand_nxt = w_chk.code;
                    end
                end
                LOCK: begin
                    if (!w_chk.legal) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ARMED;
                    end else if (w_chk.code != r_ratio) begin
                        w_cand_nxt  = w_chk.code;
                        w_state_nxt = CHECK;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = IDLE;
            w_stall_nxt = 1'b1;
        end
    end

    // Outputs are registered from the next-state decode so they move on the
    // same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ratio <= DIV2;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_ratio <= w_ratio_nxt;
            r_valid <= (w_state_nxt == LOCK);
            r_err   <= w_err_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    assign ratio = r_ratio;
    assign valid = r_valid;
    assign err   = r_err;
    assign stall = r_stall;

endmodule

// File: tb/tb_div_ratio_detect.sv
// Randomized and directed bench for div_ratio_detect against a period/duty
// reference model.
module tb_div_ratio_detect;

    localparam int unsigned PER_W       = 5;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          PMAX        = (1 << PER_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CHECK = 2;
    localparam int M_LOCK  = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       clk_in = 1'b0;
    logic [1:0] ratio;
    logic       valid;
    logic       err;
    logic       stall;

    div_ratio_detect #(
        .PER_W      (PER_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_in(clk_in),
        .ratio (ratio),
        .valid (valid),
        .err   (err),
        .stall (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_seen = 0;
    int lock_cyc = -1;

    // Reference model state
    int         m_t     = 0;
    int         m_last  = 1;
    int         m_hcnt  = 0;
    int         m_state = M_IDLE;
    logic [1:0] m_cand  = 2'd0;
    logic [1:0] m_ratio = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_stall = 1'b0;
    bit         q[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model: q holds the raw clk_in samples; the synchronized level seen in
    // a cycle is the sample taken SYNC_STAGES edges earlier.
    always @(posedge clk or posedge rst) begin : model
        bit ms, msd, mrise, legal;
        int p, h, code;
        if (rst) begin
            m_t     = 0;
            m_last  = 1;
            m_hcnt  = 0;
            m_state = M_IDLE;
            m_cand  = 2'd0;
            m_ratio = 2'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_stall = 1'b0;
            q.delete();
            for (int i = 0; i < int'(SYNC_STAGES) + 2; i++) q.push_back(1'b0);
        end else begin
            m_t++;
            q.push_back(clk_in);
            void'(q.pop_front());
            ms    = q[1];
            msd   = q[0];
            mrise = ms & ~msd;
            m_err = 1'b0;
            if (mrise) begin
                p       = imin(m_t - m_last, PMAX);
                h       = m_hcnt;
                m_last  = m_t;
                m_hcnt  = 1;
                m_stall = 1'b0;
                legal   = (p == 2 || p == 4 || p == 8 || p == 16) && (2 * h == p);
                code    = (p == 2) ? 0 : (p == 4) ? 1 : (p == 8) ? 2 : 3;
                case (m_state)
                    M_IDLE: m_state = M_ARMED;
                    M_ARMED: begin
                        if (legal) begin
                            m_cand  = 2'(code);
                            m_state = M_CHECK;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    M_CHECK: begin
                        if (!legal) begin
                            m_err   = 1'b1;
                            m_state = M_ARMED;
                        end else if (2'(code) == m_cand) begin
                            m_ratio = m_cand;
                            m_state = M_LOCK;
                        end else begin
                            m_cand = 2'(code);
                        end
                    end
                    default: begin
                        if (!legal) begin
                            m_err   = 1'b1;
                            m_state = M_ARMED;
                        end else if (2'(code) != m_ratio) begin
                            m_cand  = 2'(code);
                            m_state = M_CHECK;
                        end
                    end
                endcase
            end else begin
                if (ms) m_hcnt = imin(m_hcnt + 1, PMAX);
                if (m_state != M_IDLE && imin(m_t - m_last, PMAX) == PMAX) begin
                    m_state = M_IDLE;
                    m_stall = 1'b1;
                end
            end
            m_valid = (m_state == M_LOCK);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One system cycle: compare DUT to model, then drive the next clk_in level.
    task automatic tick(input logic v);
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("valid", 32'(valid), 32'(m_valid));
            chk("ratio", 32'(ratio), 32'(m_ratio));
            chk("err",   32'(err),   32'(m_err));
            chk("stall", 32'(stall), 32'(m_stall));
            if (err) err_seen++;
            if (valid && lock_cyc < 0) lock_cyc = cyc;
        end
        clk_in = v;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1);
            for (int i = 0; i < lo; i++) tick(1'b0);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        clk_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ratio", 32'(ratio), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst      = 1'b0;
        err_seen = 0;
        lock_cyc = -1;
    endtask

    initial begin
        int first;
        int n;
        int kind;

        // Lock on each ratio from a clean start
        for (int k = 0; k < 4; k++) begin
            n = 2 << k;
            do_reset();
            first = cyc + 1;
            wave(n / 2, n / 2, 4);
            chk("lock_valid",   32'(valid), 32'd1);
            chk("lock_ratio",   32'(ratio), 32'(k));
            chk("lock_noerr",   32'(err_seen), 32'd0);
            chk("lock_latency", 32'(lock_cyc - first), 32'(2 * n + 3));
            chk("model_ratio",  32'(m_ratio), 32'(k));
        end

        // Ratio switch /4 -> /16 at a period boundary
        do_reset();
        wave(2, 2, 4);
        chk("sw_pre_valid", 32'(valid), 32'd1);
        chk("sw_pre_ratio", 32'(ratio), 32'd1);
        wave(8, 8, 3);
        chk("sw_valid", 32'(valid), 32'd1);
        chk("sw_ratio", 32'(ratio), 32'd3);
        chk("sw_noerr", 32'(err_seen), 32'd0);

        // Bad duty: period 8 with 3 high cycles
        do_reset();
        wave(3, 5, 6);
        hold(1'b0, 8);
        chk("duty_errs",  32'(err_seen), 32'd5);
        chk("duty_valid", 32'(valid), 32'd0);

        // Illegal period 6, then legal /8
        do_reset();
        wave(3, 3, 5);
        wave(4, 4, 4);
        chk("p6_errs",  32'(err_seen), 32'd5);
        chk("p6_valid", 32'(valid), 32'd1);
        chk("p6_ratio", 32'(ratio), 32'd2);

        // Stall while locked at /8, then resume
        do_reset();
        wave(4, 4, 4);
        chk("st_pre_valid", 32'(valid), 32'd1);
        hold(1'b0, 40);
        chk("st_stall", 32'(stall), 32'd1);
        chk("st_valid", 32'(valid), 32'd0);
        chk("model_stall", 32'(m_stall), 32'd1);
        wave(4, 4, 1);
        chk("st_clear", 32'(stall), 32'd0);
        wave(4, 4, 3);
        chk("st_relock", 32'(valid), 32'd1);
        chk("st_ratio",  32'(ratio), 32'd2);

        // Asynchronous reset pulse while locked at /2
        do_reset();
        wave(1, 1, 6);
        chk("rm_pre_valid", 32'(valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_valid", 32'(valid), 32'd0);
        chk("rm_ratio", 32'(ratio), 32'd0);
        chk("rm_err",   32'(err),   32'd0);
        chk("rm_stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        err_seen = 0;
        wave(1, 1, 5);
        chk("rm_relock", 32'(valid), 32'd1);
        chk("rm_ratio2", 32'(ratio), 32'd0);

        // Randomized segments checked cycle by cycle against the model
        do_reset();
        for (int s = 0; s < 60; s++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                do_reset();
            end else if (kind <= 5) begin
                n = 2 << $urandom_range(0, 3);
                wave(n / 2, n / 2, int'($urandom_range(1, 5)));
            end else if (kind <= 7) begin
                wave(int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
                     int'($urandom_range(1, 4)));
            end else begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 45)));
            end
        end
        hold(1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ratio_detect.md
# div_ratio_detect

Measures a divided clock waveform, sampled in the system clock domain, and reports which of the four switch-selected division ratios (÷2, ÷4, ÷8, ÷16) it carries. It is the receiving end of the `sw`-selectable clock divider: the divider generates `clk_O`, and this block recovers the ratio code from it. It checks duty cycle, requires two consecutive matching periods before locking, and flags malformed or stalled input.

## Interface
Parameters:
- `PER_W`, default 5: period/high-time counter width. It must be at least 5 so the counter reaches 16 cycles and still has room for the saturation value.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `clk_in`. The minimum is 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all logic is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_in`  in  1  divided clock under measurement. It is treated as asynchronous.
- `ratio`  out  2  decoded code: 00=÷2, 01=÷4, 10=÷8, 11=÷16. The value is meaningful only while `valid`=1.
- `valid`  out  1  level; asserted while the block is locked.
- `err`  out  1  one-cycle pulse for each illegal period or duty cycle.
- `stall`  out  1  level; set on timeout and cleared by the next detected rise.

## Operation
- **Sampling:** `clk_in` passes through `SYNC_STAGES` flops to give `s`, plus one more flop to give `s_d`. A rise is `rise = s & ~s_d`.
- **Period counter `per_cnt`:**
  - On `rise`, the counter latches P = `per_cnt` and then loads 1.
  - Otherwise it increments, saturating at PER_MAX = 2^PER_W−1.
- **High counter `hi_cnt`:**
  - On `rise`, the counter latches H = `hi_cnt` and then loads 1.
  - Otherwise it increments when `s`=1 and saturates.
- **Legality:** a period is legal when P ∈ {2,4,8,16} and H = P/2.
  - code = log2(P)−1.
  - Any other P/H pair is illegal.
- **FSM states:** IDLE, ARMED, CHECK, LOCK. `cand` is a 2-bit candidate register.
  - IDLE: on `rise`, go to ARMED. The first rise measures nothing.
  - ARMED: on a legal rise, set `cand`←code and go to CHECK. On an illegal rise, pulse `err` and stay in ARMED.
  - CHECK: on a legal rise with code = `cand`, go to LOCK and set `ratio`←`cand`. On a legal rise with code ≠ `cand`, set `cand`←code and stay in CHECK. On an illegal rise, pulse `err` and go to ARMED.
  - LOCK: on a legal rise with code = `ratio`, stay in LOCK. On a legal rise with a different code, set `cand`←code and go to CHECK (`valid` drops). On an illegal rise, pulse `err` and go to ARMED.
- **Timeout:** in any state other than IDLE, `per_cnt` = PER_MAX with no rise sends the FSM to IDLE and sets `stall`=1. It also forces `valid`=0 and produces no `err` pulse.
- **Valid:** `valid` = (state == LOCK), registered.
- **Ratio hold:** `ratio` holds its last locked value after a drop. Consumers must gate it with `valid`.
- **Simultaneous events:** `rise` takes priority over timeout in the same cycle.

## Timing
- **Reset values:**
  - `ratio`=00, `valid`=0, `err`=0, `stall`=0
  - state=IDLE, `per_cnt`=0, `hi_cnt`=0, `cand`=00
  - synchronizer flops=0
- **Edge latency:** a `clk_in` rising edge produces `rise` SYNC_STAGES+1 `clk` edges later, i.e. 3 edges by default.
- **Output timing:** all outputs are registered. `err`, `valid` and `ratio` change on the `clk` edge after the `rise` cycle.
- **Lock latency:** from reset release with a clean input, `valid` rises on the edge after the 3rd detected rise. For ÷N this is 2N cycles after the first detected rise, plus 1.
- **Ratio change while locked:** `valid` falls 1 cycle after the first differing rise. It re-asserts 1 cycle after the second matching rise of the new ratio.
- **Timeout timing:** `stall` asserts 1 cycle after `per_cnt` reaches PER_MAX, i.e. 31 cycles without a rise at default width.
- **Reset mid-operation:** asserting `rst` clears all state immediately and asynchronously. After release, lock restarts from IDLE.
- **Constant input:** `clk_in` held at 0 or at 1 never produces `rise`. The only possible outcome is `stall`.

## Structure
- **Package `div_ratio_pkg`:**
  - FSM state enum: IDLE, ARMED, CHECK, LOCK
  - ratio code constants: `DIV2`=00, `DIV4`=01, `DIV8`=10, `DIV16`=11
  - legal period constants: 2, 4, 8, 16
  - helper function `period_to_code` returning {legal, code}
- **Sub-module `edge_sync`:** parameterized synchronizer chain with rise-detect output. It is reusable for any asynchronous input.
- **Top level:** `div_ratio_detect` contains the counters, legality check and FSM.

## Test plan
- **Lock on each ratio:** reset for 20 ns, then drive the matching divider at sw=00/01/10/11 (÷2/4/8/16). Required: `valid`=1 and `ratio`=00/01/10/11 respectively within 3 periods plus 4 cycles, and no `err` pulse.
- **Ratio switch:** locked at ÷4, switch to ÷16 mid-run. Required: `valid` falls within 4 cycles of the first 16-cycle rise, then re-locks with `ratio`=11 after a second period; zero `err` if the switch occurs at a period boundary.
- **Bad duty:** a period-8 input with a 3-cycle high time. Required: one `err` pulse per period, `valid` stays 0, and the FSM cycles ARMED→ARMED.
- **Illegal period:** a 6-cycle period at 50% duty. Required: an `err` pulse every rise and no lock. Switching back to a legal 8-cycle input then locks with `ratio`=10.
- **Stall:** locked at ÷8, then hold `clk_in`=0. Required: `stall`=1 and `valid`=0 31 cycles after the last rise. Resuming ÷8 clears `stall` at the first rise and re-locks after two further rises.
- **Reset mid-lock:** pulse `rst` for 1 cycle while locked at ÷2. Required: all outputs drop to their reset values asynchronously, and lock returns with `ratio`=00 within 3 periods plus 4 cycles.
